// File: rtl/fp_sqrt_round_pack.sv
// Normalises, rounds (RISC-V rm) and packs the mantissa-sqrt root into an IEEE-754 single with fflags.
// Latency: 2 cycles from input accept to out_valid, 1 beat/cycle throughput.
// Backpressure: out_ready_i low stalls stage 2; in_ready drops once stage 1 is also full. Data regs hold while stalled.
module fp_sqrt_round_pack #(
    parameter int ROOT_W    = 254,
    parameter int ROOT_FRAC = 250,
    parameter int EXP_W     = 8,
    parameter int FRAC_W    = 23
) (
    input  logic                      in_Clk,
    input  logic                      in_Rst_N,
    input  logic                      in_valid,
    input  logic                      out_ready_i,
    output logic                      in_ready,
    input  logic [ROOT_W-1:0]         in_root,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic                      in_sign,
    input  logic [1:0]                in_class,
    input  logic                      in_nv,
    input  logic [2:0]                in_rm,
    output logic                      out_valid,
    output logic [EXP_W+FRAC_W:0]     out_data,
    output logic [4:0]                out_flags
);

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_PINF = 2'b10,
        CLS_NAN  = 2'b11
    } class_t;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EXP_W+FRAC_W:0] PINF_PAT = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [EXP_W+FRAC_W:0] QNAN_PAT = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_v, s2_v;
    logic s2_adv, s1_load;

    assign s2_adv    = !s2_v || out_ready_i;
    assign in_ready  = !s1_v || s2_adv;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_v;

    // ------------------------------------------------------------------
    // Stage 1: normalise so the leading one sits just above the fraction
    // ------------------------------------------------------------------
    logic              b1, b0;
    logic [FRAC_W-1:0] n_frac;
    logic              n_g, n_s;
    logic [EXP_W-1:0]  n_exp;

    assign b1 = in_root[ROOT_FRAC+1];
    assign b0 = in_root[ROOT_FRAC];

    always_comb begin
        n_frac = '0;
        n_g    = 1'b0;
        n_s    = 1'b0;
        n_exp  = in_exp;
        if (b1) begin
            n_frac = in_root[ROOT_FRAC -: FRAC_W];
            n_g    = in_root[ROOT_FRAC-FRAC_W];
            n_s    = |in_root[ROOT_FRAC-FRAC_W-1:0];
            n_exp  = in_exp + EXP_W'(1);
        end else if (b0) begin
            n_frac = in_root[ROOT_FRAC-1 -: FRAC_W];
            n_g    = in_root[ROOT_FRAC-1-FRAC_W];
            n_s    = |in_root[ROOT_FRAC-2-FRAC_W:0];
        end else begin
            // Root just below 1.0: the iterative unit guarantees the leading one is one bit lower.
            n_frac = in_root[ROOT_FRAC-2 -: FRAC_W];
            n_g    = in_root[ROOT_FRAC-2-FRAC_W];
            n_s    = |in_root[ROOT_FRAC-3-FRAC_W:0];
            n_exp  = in_exp - EXP_W'(1);
        end
    end

    logic [FRAC_W-1:0] s1_frac;
    logic              s1_g, s1_s;
    logic [EXP_W-1:0]  s1_exp;
    class_t            s1_class;
    logic              s1_sign, s1_nv;
    logic [2:0]        s1_rm;

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            s1_v     <= 1'b0;
            s1_frac  <= '0;
            s1_g     <= 1'b0;
            s1_s     <= 1'b0;
            s1_exp   <= '0;
            s1_class <= CLS_NORM;
            s1_sign  <= 1'b0;
            s1_nv    <= 1'b0;
            s1_rm    <= '0;
        end else begin
            if (s1_load) begin
                s1_v     <= 1'b1;
                s1_frac  <= n_frac;
                s1_g     <= n_g;
                s1_s     <= n_s;
                s1_exp   <= n_exp;
                s1_class <= class_t'(in_class);
                s1_sign  <= in_sign;
                s1_nv    <= in_nv;
                s1_rm    <= in_rm;
            end else if (s2_adv) begin
                s1_v <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack
    // ------------------------------------------------------------------
    logic                     inc;
    logic                     carry;
    logic [FRAC_W-1:0]        r_frac;
    logic [EXP_W-1:0]         r_exp;
    logic [EXP_W+FRAC_W:0]    p_data;
    logic [4:0]               p_flags;

    always_comb begin
        inc = 1'b0;
        case (s1_rm)
            RM_RTZ, RM_RDN: inc = 1'b0;
            RM_RUP:         inc = s1_g | s1_s;
            RM_RMM:         inc = s1_g;
            default:        inc = s1_g & (s1_s | s1_frac[0]);
        endcase
    end

    assign {carry, r_frac} = {1'b0, s1_frac} + {{FRAC_W{1'b0}}, inc};
    assign r_exp           = carry ? s1_exp + EXP_W'(1) : s1_exp;

    always_comb begin
        p_data  = '0;
        p_flags = '0;
        case (s1_class)
            CLS_ZERO: p_data = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            CLS_PINF: p_data = PINF_PAT;
            CLS_NAN: begin
                p_data     = QNAN_PAT;
                p_flags[4] = s1_nv;
            end
            default: begin
                // A square root is never negative, so the sign bit is fixed at 0.
                p_data     = {1'b0, r_exp, r_frac};
                p_flags[0] = s1_g | s1_s;
            end
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            s2_v      <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_data  <= p_data;
                out_flags <= p_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_sqrt_round_pack.sv
// Bench for fp_sqrt_round_pack: directed corner cases, backpressure/ordering, random beats
// against an arithmetic reference model, and asynchronous reset flush.
module tb_fp_sqrt_round_pack;

    logic         in_Clk = 1'b0;
    logic         in_Rst_N = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready_i = 1'b0;
    logic         in_ready;
    logic [253:0] in_root = '0;
    logic [7:0]   in_exp = '0;
    logic         in_sign = 1'b0;
    logic [1:0]   in_class = '0;
    logic         in_nv = 1'b0;
    logic [2:0]   in_rm = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [4:0]   out_flags;

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int popped = 0;
    bit mon_en = 1'b0;
    logic [36:0] exp_q[$];

    fp_sqrt_round_pack dut (
        .in_Clk      (in_Clk),
        .in_Rst_N    (in_Rst_N),
        .in_valid    (in_valid),
        .out_ready_i (out_ready_i),
        .in_ready    (in_ready),
        .in_root     (in_root),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .in_class    (in_class),
        .in_nv       (in_nv),
        .in_rm       (in_rm),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_flags   (out_flags)
    );

    always #5 in_Clk = ~in_Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: value-level rounding of root/2^250 * 2^(exp-127), result {flags, data}.
    function automatic logic [36:0] model(input logic [253:0] r, input logic [7:0] e, input logic sg,
                                          input logic [1:0] cls, input logic nv, input logic [2:0] rm);
        logic [253:0] one, rem, half, mant;
        logic [31:0]  d;
        logic         up;
        int           pos, sh;
        one = 254'd1;
        case (cls)
            2'b01: return {5'd0, sg, 31'd0};
            2'b10: return {5'd0, 32'h7F800000};
            2'b11: return {nv, 4'd0, 32'h7FC00000};
            default: ;
        endcase
        pos  = r[251] ? 251 : (r[250] ? 250 : 249);
        sh   = pos - 23;
        mant = r >> sh;
        rem  = r & ((one << sh) - one);
        half = one << (sh - 1);
        d    = {1'b0, 8'(e + 8'(pos - 250)), mant[22:0]};
        case (rm)
            3'd1, 3'd2: up = 1'b0;
            3'd3:       up = (rem != 0);
            3'd4:       up = (rem >= half);
            default:    up = (rem > half) || ((rem == half) && mant[0]);
        endcase
        return {4'd0, (rem != 0), d + 32'(up)};
    endfunction

    always @(negedge in_Clk) begin
        if (mon_en && in_Rst_N) begin
            if (out_valid && out_ready_i) begin
                chk("sb_underflow", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    chk("sb_data", 64'(out_data), 64'(e[31:0]));
                    chk("sb_flags", 64'(out_flags), 64'(e[36:32]));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_root, in_exp, in_sign, in_class, in_nv, in_rm));
                pushed++;
            end
        end
    end

    function automatic logic [253:0] rand_root();
        logic [253:0] r, one;
        int p;
        one = 254'd1;
        r = '0;
        repeat (8) r = (r << 32) | 254'($urandom);
        p = $urandom_range(249, 251);
        r = r & ((one << (p + 1)) - one);
        r = r | (one << p);
        if ($urandom_range(0, 3) == 0) r = r & ~((one << (p - 24)) - one);
        return r;
    endfunction

    task automatic set_rand_beat();
        int c;
        c        = $urandom_range(0, 7);
        in_root  = rand_root();
        in_exp   = 8'($urandom_range(2, 250));
        in_sign  = 1'($urandom);
        in_class = (c < 5) ? 2'b00 : 2'(c - 4);
        in_nv    = 1'($urandom);
        in_rm    = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_beat(input bit rand_rdy);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge in_Clk);
            acc = in_ready;
            @(posedge in_Clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic directed(input string tag, input logic [253:0] r, input logic [7:0] e, input logic sg,
                            input logic [1:0] cls, input logic nv, input logic [2:0] rm,
                            input logic [31:0] xd, input logic [4:0] xf);
        out_ready_i = 1'b1;
        in_root = r; in_exp = e; in_sign = sg; in_class = cls; in_nv = nv; in_rm = rm;
        in_valid = 1'b1;
        @(posedge in_Clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge in_Clk);
        #1;
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(xd));
        chk({tag, "_flags"}, 64'(out_flags), 64'(xf));
    endtask

    initial begin
        logic [253:0] one, sq2;
        logic [31:0]  held;
        int           cnt;
        one = 254'd1;
        sq2 = 254'h16A09E667F3BCC908B2FB1366EA957D3E << 122;

        // Reset state
        repeat (2) @(posedge in_Clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        in_Rst_N = 1'b1;
        @(posedge in_Clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // Directed corner cases
        directed("one_rne",   one << 250,                     8'd127, 1'b0, 2'b00, 1'b0, 3'd0, 32'h3F800000, 5'h00);
        directed("sqrt2_rne", sq2,                            8'd127, 1'b0, 2'b00, 1'b0, 3'd0, 32'h3FB504F3, 5'h01);
        directed("sqrt2_rup", sq2,                            8'd127, 1'b0, 2'b00, 1'b0, 3'd3, 32'h3FB504F4, 5'h01);
        directed("near2_rne", (one << 251) - (one << 220),    8'd127, 1'b0, 2'b00, 1'b0, 3'd0, 32'h40000000, 5'h01);
        directed("near2_rtz", (one << 251) - (one << 220),    8'd127, 1'b0, 2'b00, 1'b0, 3'd1, 32'h3FFFFFFF, 5'h01);
        directed("two5_rtz",  (one << 251) | (one << 249),    8'd127, 1'b0, 2'b00, 1'b0, 3'd1, 32'h40200000, 5'h00);
        directed("nan_nv",    rand_root(),                    8'd12,  1'b1, 2'b11, 1'b1, 3'd0, 32'h7FC00000, 5'h10);
        directed("zero_neg",  rand_root(),                    8'd12,  1'b1, 2'b01, 1'b1, 3'd0, 32'h80000000, 5'h00);
        directed("pinf",      rand_root(),                    8'd12,  1'b1, 2'b10, 1'b1, 3'd3, 32'h7F800000, 5'h00);
        directed("sub1_rne",  (one << 250) - (one << 200),    8'd127, 1'b0, 2'b00, 1'b0, 3'd0, 32'h3F800000, 5'h01);

        // Back-to-back beats with 3 stalled cycles
        @(posedge in_Clk);
        #1;
        out_ready_i = 1'b0;
        in_valid = 1'b1;
        set_rand_beat();
        @(negedge in_Clk);
        chk("b2b_rdy0", 64'(in_ready), 64'd1);
        @(posedge in_Clk);
        #1;
        set_rand_beat();
        @(negedge in_Clk);
        chk("b2b_rdy1", 64'(in_ready), 64'd1);
        @(posedge in_Clk);
        #1;
        set_rand_beat();
        @(negedge in_Clk);
        chk("b2b_rdy_drop", 64'(in_ready), 64'd0);
        chk("b2b_vld_stall", 64'(out_valid), 64'd1);
        held = out_data;
        @(posedge in_Clk);
        #1;
        chk("b2b_hold", 64'(out_data), 64'(held));
        out_ready_i = 1'b1;
        drive_beat(1'b0);
        set_rand_beat();
        drive_beat(1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            set_rand_beat();
            drive_beat(1'b1);
        end

        out_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge in_Clk);
            #1;
        end
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("all_emitted", 64'(popped), 64'(pushed));

        // Reset with two beats in flight
        mon_en = 1'b0;
        @(posedge in_Clk);
        #1;
        set_rand_beat();
        in_valid = 1'b1;
        @(posedge in_Clk);
        #1;
        set_rand_beat();
        @(posedge in_Clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_vld", 64'(out_valid), 64'd1);
        in_Rst_N = 1'b0;
        #1;
        chk("async_rst_vld", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_flags", 64'(out_flags), 64'd0);
        @(posedge in_Clk);
        #1;
        in_Rst_N = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge in_Clk);
            if (out_valid) cnt++;
        end
        chk("post_rst_quiet", 64'(cnt), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
